// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the MIPS front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_word_select.sv
// Picks one 32-bit word out of the flat instruction stream and flags whether the index exists.
// Latency: purely combinational.
// Backpressure: none; out-of-range indices return zero with in_range low.
module instr_word_select
    import mips_pkg::*;
#(
    parameter int NUM_WORDS = 1024
) (
    input  logic [INSTR_W*NUM_WORDS-1:0] stream,
    input  logic [29:0]                  word_idx,
    output logic [INSTR_W-1:0]           word,
    output logic                         in_range
);

    assign in_range = ({2'b00, word_idx} < 32'(NUM_WORDS));

    always_comb begin
        word = NOP_INSTR;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_idx == 30'(i)) begin
                word = stream[INSTR_W*i +: INSTR_W];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC and fills the IF/ID latch; IF_FETCH_COUNT_EN adds a saturating fetch counter.
// Latency: instruction at pc appears on if_id_* one clock after fetch; first valid 2 clocks after rst falls.
// Backpressure: stall holds pc and latch; flush inserts a bubble; redirect overrides both.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INSTR_W*NUM_WORDS-1:0] instruction_stream,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic [31:0]                  pc,
    output logic [INSTR_W-1:0]           if_id_instr,
    output logic [31:0]                  if_id_pc_plus4,
    output logic                         if_id_valid,
    output logic                         fetch_done
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]                  fetch_count
`endif
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [31:0]        if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               fetch_done_q, fetch_done_d;

    logic [INSTR_W-1:0] fetch_word;
    logic               fetch_in_range;
    logic [31:0]        pc_next_seq;
    logic [31:0]        redirect_tgt;
    logic               redirect_in_range;
    logic               fetch_fire;

    instr_word_select #(
        .NUM_WORDS (NUM_WORDS)
    ) u_word_select (
        .stream   (instruction_stream),
        .word_idx (pc_q[31:2]),
        .word     (fetch_word),
        .in_range (fetch_in_range)
    );

    assign pc_next_seq       = pc_q + PC_STEP;
    assign redirect_tgt      = redirect_pc & ~32'h3;
    assign redirect_in_range = ({2'b00, redirect_tgt[31:2]} < 32'(NUM_WORDS));
    assign fetch_fire        = (state_q == RUN) && !redirect_valid && fetch_in_range
                               && !flush && !stall;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        fetch_done_d     = fetch_done_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_d          = redirect_tgt;
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end else if (!fetch_in_range) begin
                    // Stream exhausted: park with pc pointing just past the last word.
                    state_d       = HALT;
                    if_id_valid_d = 1'b0;
                    fetch_done_d  = 1'b1;
                end else if (flush) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    if (!stall) begin
                        pc_d = pc_next_seq;
                    end
                end else if (fetch_fire) begin
                    if_id_instr_d    = fetch_word;
                    if_id_pc_plus4_d = pc_next_seq;
                    if_id_valid_d    = 1'b1;
                    pc_d             = pc_next_seq;
                end
            end
            HALT: begin
                if (redirect_valid && redirect_in_range) begin
                    state_d      = RUN;
                    fetch_done_d = 1'b0;
                    pc_d         = redirect_tgt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_plus4_q <= 32'h0;
            if_id_valid_q    <= 1'b0;
            fetch_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
            fetch_done_q     <= fetch_done_d;
        end
    end

    assign pc             = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;
    assign fetch_done     = fetch_done_q;

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (fetch_fire && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural model predicts each cycle's outputs.
// Latency: stimulus applied on negedge, checked 1ns after the following posedge.
// Backpressure: stall/flush/redirect driven both directed and randomly.
module tb_instr_fetch_unit;

    localparam int N = 8;

    logic              clk;
    logic              rst;
    logic [32*N-1:0]   stream;
    logic              stall, flush, redirect_valid;
    logic [31:0]       redirect_pc;
    logic [31:0]       pc, if_id_instr, if_id_pc_plus4;
    logic              if_id_valid, fetch_done;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0]       fetch_count;
`endif

    instr_fetch_unit #(.NUM_WORDS(N), .RESET_PC(32'h0)) dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_stream (stream),
        .stall              (stall),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .pc                 (pc),
        .if_id_instr        (if_id_instr),
        .if_id_pc_plus4     (if_id_pc_plus4),
        .if_id_valid        (if_id_valid),
        .fetch_done         (fetch_done)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count        (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        done;
        logic [31:0] count;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem[N];

    // Reference model: memory array plus a few booleans describing where the fetcher is.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_done;
    bit          m_started, m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
        m_valid = 1'b0; m_done = 1'b0; m_started = 0; m_halted = 0;
    endtask

    task automatic model_clock(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
        end else if (m_halted) begin
            if (rv && (tgt / 4) < N) begin
                m_halted = 0; m_done = 1'b0; m_pc = tgt;
            end
        end else if (rv) begin
            m_pc = tgt; m_valid = 1'b0; m_instr = 32'h0;
        end else if ((m_pc / 4) >= N) begin
            m_halted = 1; m_done = 1'b1; m_valid = 1'b0;
        end else if (fl) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (!st) m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_instr = mem[m_pc / 4];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then wait for the next negedge.
    task automatic step(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
        exp_t e;
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        model_clock(st, fl, rv, rpc);
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.done = m_done; e.count = m_count;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    pc,             32'h0);
        chk({tag, "_instr"}, if_id_instr,    32'h0);
        chk({tag, "_pc4"},   if_id_pc_plus4, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_done"},  {31'b0, fetch_done},  32'h0);
    endtask

    // Monitor: pops one prediction per clock whenever one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc",    pc,             e.pc);
                chk("instr", if_id_instr,    e.instr);
                chk("pc4",   if_id_pc_plus4, e.pc4);
                chk("valid", {31'b0, if_id_valid}, {31'b0, e.valid});
                chk("done",  {31'b0, fetch_done},  {31'b0, e.done});
`ifdef IF_FETCH_COUNT_EN
                chk("count", fetch_count, e.count);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        mem[0] = 32'h20010001; mem[1] = 32'h00210820;
        mem[2] = 32'h20010007; mem[3] = 32'h00210820;
        mem[5] = 32'h0000_0000;
        for (int i = 0; i < N; i++) stream[32*i +: 32] = mem[i];
        model_reset();
        #3;
        chk_reset_state("reset");

        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);                 // IDLE cycle
        step(0, 0, 0, 0);                 // w0
        step(0, 0, 0, 0);                 // w1, pc=8
        repeat (3) step(1, 0, 0, 0);      // hold w1 / pc=8
        step(0, 0, 0, 0);                 // w2
        step(1, 0, 1, 32'h0000_0006);     // redirect beats stall
        step(0, 0, 0, 0);                 // w1 again

        for (int k = 0; k < 4 * N && !m_halted; k++) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);      // HALT holds
        step(0, 0, 1, 32'h0000_0100);     // out-of-range redirect ignored
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0000);     // back to RUN
        step(0, 0, 0, 0);                 // w0 reappears
        step(0, 1, 0, 0);                 // flush advances pc
        step(1, 1, 0, 0);                 // flush+stall holds pc
        step(0, 0, 0, 0);

        repeat (600) begin
            bit          st, fl, rv;
            logic [31:0] tgt;
            r   = $urandom_range(0, 99);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 6) == 0);
            rv  = (r < 10);
            tgt = $urandom_range(0, 4 * N + 12);
            step(st, fl, rv, tgt);
        end

        // Asynchronous reset between edges with pc at 12.
        step(0, 0, 1, 32'h0);
        repeat (3) step(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
